stream_demux: RTL and testbench

//  1-to-N packet stream demultiplexer: routes one valid/ready input stream to one of N_CH output channels.

---
 rtl/stream_demux_pkg.sv | 23 ++
 rtl/stream_demux_hold.sv | 86 ++++++++
 rtl/stream_demux.sv | 119 +++++++++++
 tb/tb_stream_demux.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// -----------------------------------------------------------------------------
// stream_demux_pkg
// Shared types and constants for the stream_demux block.
//   state_e : routing FSM states (ST_IDLE waits for a packet's first beat,
//             ST_PKT keeps routing to the locked channel until the last beat)
//   CNT_W   : width of each optional per-channel packet counter
//   sel_w() : channel-select width for a given channel count
// -----------------------------------------------------------------------------
package stream_demux_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_e;

  localparam int CNT_W = 8;

  // Never narrower than one bit, so a select port always exists.
  function automatic int sel_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage : stream_demux_pkg

// File: rtl/stream_demux_hold.sv
// -----------------------------------------------------------------------------
// stream_demux_hold
// One-entry valid/ready register slice carrying payload, destination channel
// and last flag. Supports a full beat per cycle: a drain and a reload in the
// same cycle keep the entry valid with no bubble.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   in_valid_i    upstream beat valid
//   in_ready_o    slice can take a beat (empty, or draining this cycle)
//   in_data_i     upstream payload
//   in_ch_i       destination channel of the upstream beat
//   in_last_i     upstream last-beat flag
//   out_valid_o   slice holds a beat
//   out_ready_i   ready of the channel the held beat is destined for
//   out_data_o    held payload
//   out_ch_o      held destination channel
//   out_last_o    held last-beat flag
// -----------------------------------------------------------------------------
module stream_demux_hold #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [SEL_W-1:0]  in_ch_i,
  input  logic              in_last_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [SEL_W-1:0]  out_ch_o,
  output logic              out_last_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [SEL_W-1:0]  ch_q,    ch_d;
  logic              last_q,  last_d;
  logic              load;

  assign in_ready_o = !valid_q || out_ready_i;
  assign load       = in_valid_i && in_ready_o;

  // NOTE: every signal assigned in always_comb gets a default first so that
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
      ch_d    = in_ch_i;
      last_d  = in_last_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: the payload registers are reset along with valid because out_data
  // and out_last are observable as zero straight out of reset.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_ch_o    = ch_q;
  assign out_last_o  = last_q;

endmodule : stream_demux_hold

// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
// 1-to-N_CH packet stream demultiplexer. The destination is taken from in_sel
// on a packet's first beat and held until in_last is accepted. One registered
// output stage (stream_demux_hold) drives a shared data bus qualified by a
// one-hot per-channel valid.
// Optional feature macro: STREAM_DEMUX_PKT_CNT_EN adds 8-bit wrapping
// per-channel packet counters on port pkt_cnt (channel c at pkt_cnt[c*8+:8]).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   pkt_cnt     per-channel packet counts (only with STREAM_DEMUX_PKT_CNT_EN)
//   in_valid    input beat valid
//   in_ready    input beat accepted when in_valid & in_ready
//   in_data     input payload
//   in_sel      destination channel, sampled on a packet's first beat only
//   in_last     final beat of packet
//   out_valid   one-hot (or zero) per-channel valid
//   out_ready   per-channel ready
//   out_data    shared payload bus
//   out_last    final-beat flag
// -----------------------------------------------------------------------------
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int N_CH   = 4,
  localparam int SEL_W  = sel_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef STREAM_DEMUX_PKT_CNT_EN
  output logic [N_CH*CNT_W-1:0] pkt_cnt,
`endif
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_last,
  output logic [N_CH-1:0]       out_valid,
  input  logic [N_CH-1:0]       out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] lock_q,  lock_d;
  logic [SEL_W-1:0] route_ch;
  logic             accept;
  logic             hold_valid;
  logic [SEL_W-1:0] hold_ch;
  logic             hold_ready;

  // Mid-packet beats ignore in_sel and follow the channel locked on beat one.
  assign route_ch   = (state_q == ST_PKT) ? lock_q : in_sel;
  assign accept     = in_valid && in_ready;
  // Only the ready of the channel the held beat targets matters.
  assign hold_ready = out_ready[hold_ch];

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    unique case (state_q)
      ST_IDLE: if (accept && !in_last) begin
        state_d = ST_PKT;
        lock_d  = in_sel;
      end
      ST_PKT:  if (accept && in_last) begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  stream_demux_hold #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_hold (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_ch_i     (route_ch),
    .in_last_i   (in_last),
    .out_valid_o (hold_valid),
    .out_ready_i (hold_ready),
    .out_data_o  (out_data),
    .out_ch_o    (hold_ch),
    .out_last_o  (out_last)
  );

  assign out_valid = hold_valid ? (N_CH'(1) << hold_ch) : '0;

`ifdef STREAM_DEMUX_PKT_CNT_EN
  // A packet counts when its last beat completes the output handshake.
  for (genvar c = 0; c < N_CH; c++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (out_valid[c] && out_ready[c] && out_last) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
    assign pkt_cnt[c*CNT_W +: CNT_W] = cnt_q;
  end
`endif

endmodule : stream_demux

// File: tb/tb_stream_demux.sv
// -----------------------------------------------------------------------------
// tb_stream_demux
// Directed bench for stream_demux (DATA_W=8, N_CH=4). The driver pushes the
// expected channel/data/last of every accepted beat into a scoreboard queue;
// an independent monitor pops and compares on each output handshake.
// Counter checks are compiled in when STREAM_DEMUX_PKT_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_stream_demux;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [1:0] in_sel = '0;
  logic       in_last = 1'b0;
  logic [3:0] out_valid;
  logic [3:0] out_ready = 4'hF;
  logic [7:0] out_data;
  logic       out_last;
`ifdef STREAM_DEMUX_PKT_CNT_EN
  logic [31:0] pkt_cnt;
`endif

  beat_t sb_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cycle    = 0;

  stream_demux #(.DATA_W(8), .N_CH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef STREAM_DEMUX_PKT_CNT_EN
    .pkt_cnt   (pkt_cnt),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the head of the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid != 4'b0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_beat", 32'(out_valid), 32'h0);
      end else if ((out_valid & out_ready) != 4'b0) begin
        beat_t e;
        e = sb_q.pop_front();
        check("mon_valid", 32'(out_valid), 32'(4'b0001 << e.ch));
        check("mon_data",  32'(out_data),  32'(e.data));
        check("mon_last",  32'(out_last),  32'(e.last));
      end
    end
  end

  // Drive one beat until accepted (bounded); returns 1 ns after the accepting edge.
  task automatic send(input logic [1:0] sel, input logic [7:0] data,
                      input logic last, input logic [1:0] exp_ch);
    int  waited = 0;
    bit  done   = 0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    in_last  = last;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back('{ch: exp_ch, data: data, last: last});
        done = 1;
      end else if (++waited > 50) begin
        check("send_timeout", 32'(in_ready), 32'h1);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int waited = 0;
    while ((sb_q.size() != 0 || out_valid != 4'b0) && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    #1;
    check("drain_queue", 32'(sb_q.size()), 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    // Reset is asynchronous: outputs respond before any clock edge.
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready",  32'(in_ready),  32'h1);
    check("rst_out_data",  32'(out_data),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    // Power-on reset
    #1;
    check("por_out_valid", 32'(out_valid), 32'h0);
    check("por_in_ready",  32'(in_ready),  32'h1);
    check("por_out_last",  32'(out_last),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 3-beat packet to ch2, beat visible one cycle after acceptance
    send(2'd2, 8'hA1, 1'b0, 2'd2);
    check("lat_valid_a1", 32'(out_valid), 32'h4);
    check("lat_data_a1",  32'(out_data),  32'hA1);
    send(2'd2, 8'hA2, 1'b0, 2'd2);
    check("lat_valid_a2", 32'(out_valid), 32'h4);
    check("lat_data_a2",  32'(out_data),  32'hA2);
    send(2'd2, 8'hA3, 1'b1, 2'd2);
    check("lat_valid_a3", 32'(out_valid), 32'h4);
    check("lat_data_a3",  32'(out_data),  32'hA3);
    check("lat_last_a3",  32'(out_last),  32'h1);
    wait_drain();

    // Lock: in_sel toggles mid-packet, all beats stay on ch1; next packet on ch3
    send(2'd1, 8'h11, 1'b0, 2'd1);
    send(2'd0, 8'h12, 1'b0, 2'd1);
    send(2'd3, 8'h13, 1'b0, 2'd1);
    send(2'd0, 8'h14, 1'b1, 2'd1);
    send(2'd3, 8'h31, 1'b0, 2'd3);
    send(2'd0, 8'h32, 1'b1, 2'd3);
    wait_drain();

    // Backpressure on ch0 for 5 cycles; other channels ready but irrelevant
    out_ready = 4'hE;
    send(2'd0, 8'hB1, 1'b1, 2'd0);
    in_valid = 1'b1;
    in_sel   = 2'd0;
    in_data  = 8'hB2;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready",  32'(in_ready),  32'h0);
      check("stall_out_data",  32'(out_data),  32'hB1);
      check("stall_out_valid", 32'(out_valid), 32'h1);
    end
    @(posedge clk);
    #1;
    out_ready = 4'hF;
    send(2'd0, 8'hB2, 1'b1, 2'd0);
    wait_drain();

    // Back-to-back single-beat packets: one per cycle, routed by in_sel each time
    t0 = cycle;
    send(2'd0, 8'hC0, 1'b1, 2'd0);
    send(2'd1, 8'hC1, 1'b1, 2'd1);
    send(2'd2, 8'hC2, 1'b1, 2'd2);
    send(2'd3, 8'hC3, 1'b1, 2'd3);
    check("b2b_cycles", 32'(cycle - t0), 32'h4);
    wait_drain();

    // Reset mid-packet with a beat held: next beat must be a fresh first beat
    out_ready = 4'h0;
    send(2'd3, 8'hD1, 1'b0, 2'd3);
    do_reset();
    out_ready = 4'hF;
    send(2'd1, 8'hD2, 1'b1, 2'd1);
    wait_drain();

`ifdef STREAM_DEMUX_PKT_CNT_EN
    do_reset();
    check("cnt_after_rst", pkt_cnt, 32'h0);
    for (int i = 0; i < 255; i++) send(2'd1, 8'(i), 1'b1, 2'd1);
    wait_drain();
    check("cnt_ch1_255", 32'(pkt_cnt[15:8]), 32'hFF);
    send(2'd1, 8'hFF, 1'b1, 2'd1);
    wait_drain();
    check("cnt_ch1_wrap", 32'(pkt_cnt[15:8]), 32'h0);
    check("cnt_others",   32'({pkt_cnt[31:16], pkt_cnt[7:0]}), 32'h0);
    send(2'd0, 8'hE1, 1'b0, 2'd0);
    send(2'd0, 8'hE2, 1'b1, 2'd0);
    wait_drain();
    check("cnt_ch0_one", pkt_cnt, 32'h0000_0001);
    send(2'd2, 8'hE3, 1'b0, 2'd2);
    wait_drain();
    do_reset();
    check("cnt_rst_mid", pkt_cnt, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_stream_demux
